stream_demux_router: RTL and testbench



---
 rtl/stream_demux_router.sv | 148 ++++++++++++++
 tb/tb_stream_demux_router.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_demux_router.sv
// -----------------------------------------------------------------------------
// stream_demux_router
//
// Purpose:
//   1:N request router. One upstream req/gnt stream carries a destination
//   index; each accepted beat is registered in a single-entry output stage and
//   presented on exactly one of NumOut downstream req/gnt ports. Outstanding
//   transactions are counted from accept until rsp_done_i, and the destination
//   is locked while any are outstanding so responses come back in order.
//
// Ports:
//   clk_i       in   clock
//   rst_i       in   synchronous active-high reset
//   req_i       in   upstream request valid
//   sel_i       in   destination index, sampled with req_i
//   data_i      in   upstream payload
//   gnt_o       out  upstream grant (transfer on req_i && gnt_o)
//   req_o       out  one-hot downstream request
//   data_o      out  downstream payload, shared by all ports
//   gnt_i       in   downstream grants
//   rsp_done_i  in   one pulse per completed response from the locked port
//   err_o       out  sticky error flag (only with STREAM_DEMUX_ROUTER_ERR_EN)
//   idle_o      out  no buffered entry and nothing outstanding
//
// Optional feature:
//   Define STREAM_DEMUX_ROUTER_ERR_EN to add err_o. It is set by an accept
//   with an out-of-range sel_i or by rsp_done_i while nothing is outstanding,
//   and is cleared only by reset.
// -----------------------------------------------------------------------------
module stream_demux_router #(
    parameter int  NumOut   = 4,
    parameter type DataType = logic,
    parameter int  MaxTrans = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      req_i,
    input  logic [$clog2(NumOut)-1:0] sel_i,
    input  DataType                   data_i,
    output logic                      gnt_o,
    output logic [NumOut-1:0]         req_o,
    output DataType                   data_o,
    input  logic [NumOut-1:0]         gnt_i,
    input  logic                      rsp_done_i,
`ifdef STREAM_DEMUX_ROUTER_ERR_EN
    output logic                      err_o,
`endif
    output logic                      idle_o
);

    localparam int SelW     = $clog2(NumOut);
    localparam int CntWidth = $clog2(MaxTrans + 1);

    // Widened by one bit so the range check is meaningful for any NumOut.
    localparam logic [SelW:0]         NumOutW = (SelW + 1)'(NumOut);
    localparam logic [CntWidth-1:0]   MaxCnt  = CntWidth'(MaxTrans);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } stage_t;

    stage_t              r_stage;
    stage_t              w_stage_nxt;
    logic [SelW-1:0]     r_buf_sel;
    DataType             r_buf_data;
    logic [SelW-1:0]     r_lock_sel;
    logic [CntWidth-1:0] r_cnt;

    logic w_buf_vld;
    logic w_drain;
    logic w_sel_ok;
    logic w_accept;
    logic w_load;
    logic w_rsp;

    assign w_buf_vld = (r_stage == ST_FULL);
    // Only the grant of the port we are presenting on can drain the stage.
    assign w_drain   = w_buf_vld && gnt_i[r_buf_sel];
    assign w_sel_ok  = ({1'b0, sel_i} < NumOutW);

    // Independent of req_i so upstream may wait on gnt_o before raising req.
    assign gnt_o = (!w_buf_vld || w_drain)
                && (r_cnt < MaxCnt)
                && ((r_cnt == '0) || (sel_i == r_lock_sel));

    assign w_accept = req_i && gnt_o;
    // Out-of-range destinations are consumed and dropped.
    assign w_load   = w_accept && w_sel_ok;
    // A response with nothing outstanding must not wrap the counter.
    assign w_rsp    = rsp_done_i && (r_cnt != '0);

    always_comb begin
        w_stage_nxt = r_stage;
        if (w_load) begin
            w_stage_nxt = ST_FULL;
        end else if (w_drain) begin
            w_stage_nxt = ST_EMPTY;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_stage    <= ST_EMPTY;
            r_buf_sel  <= '0;
            r_buf_data <= '0;
            r_lock_sel <= '0;
            r_cnt      <= '0;
        end else begin
            r_stage <= w_stage_nxt;
            if (w_load) begin
                r_buf_sel  <= sel_i;
                r_buf_data <= data_i;
                r_lock_sel <= sel_i;
            end
            case ({w_load, w_rsp})
                2'b10:   r_cnt <= r_cnt + CntWidth'(1);
                2'b01:   r_cnt <= r_cnt - CntWidth'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

`ifdef STREAM_DEMUX_ROUTER_ERR_EN
    logic r_err;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_err <= 1'b0;
        end else if ((w_accept && !w_sel_ok) || (rsp_done_i && (r_cnt == '0))) begin
            r_err <= 1'b1;
        end
    end

    assign err_o = r_err;
`endif

    always_comb begin
        req_o = '0;
        if (w_buf_vld) begin
            req_o[r_buf_sel] = 1'b1;
        end
    end

    assign data_o = w_buf_vld ? r_buf_data : DataType'('0);
    assign idle_o = !w_buf_vld && (r_cnt == '0);

endmodule

// File: tb/tb_stream_demux_router.sv
module tb_stream_demux_router;

    localparam int NumOut   = 4;
    localparam int MaxTrans = 8;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       req_i;
    logic [1:0] sel_i;
    logic [7:0] data_i;
    logic       gnt_o;
    logic [3:0] req_o;
    logic [7:0] data_o;
    logic [3:0] gnt_i;
    logic       rsp_done_i;
    logic       idle_o;
`ifdef STREAM_DEMUX_ROUTER_ERR_EN
    logic       err_o;
`endif

    int total = 0;
    int bad   = 0;

    stream_demux_router #(
        .NumOut  (NumOut),
        .DataType(logic [7:0]),
        .MaxTrans(MaxTrans)
    ) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .req_i     (req_i),
        .sel_i     (sel_i),
        .data_i    (data_i),
        .gnt_o     (gnt_o),
        .req_o     (req_o),
        .data_o    (data_o),
        .gnt_i     (gnt_i),
        .rsp_done_i(rsp_done_i),
`ifdef STREAM_DEMUX_ROUTER_ERR_EN
        .err_o     (err_o),
`endif
        .idle_o    (idle_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1; req_i = 1'b0; sel_i = 2'd0; data_i = 8'h00;
        gnt_i = 4'b0000; rsp_done_i = 1'b0;
        tick();
        rst_i = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (req_o !== 4'b0000) begin bad++; $display("FAIL reset_req_o got=%b exp=0000", req_o); end
        total++; if (data_o !== 8'h00) begin bad++; $display("FAIL reset_data_o got=%h exp=00", data_o); end
        total++; if (idle_o !== 1'b1) begin bad++; $display("FAIL reset_idle_o got=%b exp=1", idle_o); end
        total++; if (gnt_o !== 1'b1) begin bad++; $display("FAIL reset_gnt_o got=%b exp=1", gnt_o); end
`ifdef STREAM_DEMUX_ROUTER_ERR_EN
        total++; if (err_o !== 1'b0) begin bad++; $display("FAIL reset_err_o got=%b exp=0", err_o); end
`endif
    endtask

    task automatic test_basic();
        do_reset();
        req_i = 1'b1; sel_i = 2'd2; data_i = 8'hA5; gnt_i = 4'b0000;
        #1;
        total++; if (gnt_o !== 1'b1) begin bad++; $display("FAIL basic_gnt_empty got=%b exp=1", gnt_o); end
        tick();
        total++; if (req_o !== 4'b0100) begin bad++; $display("FAIL basic_req_o got=%b exp=0100", req_o); end
        total++; if (data_o !== 8'hA5) begin bad++; $display("FAIL basic_data_o got=%h exp=a5", data_o); end
        total++; if (gnt_o !== 1'b0) begin bad++; $display("FAIL basic_gnt_full got=%b exp=0", gnt_o); end
        req_i = 1'b0;
        gnt_i = 4'b1011;
        tick();
        total++; if (req_o !== 4'b0100) begin bad++; $display("FAIL basic_other_gnt_ignored got=%b exp=0100", req_o); end
        gnt_i = 4'b0100;
        #1;
        total++; if (gnt_o !== 1'b1) begin bad++; $display("FAIL basic_gnt_drain got=%b exp=1", gnt_o); end
        tick();
        gnt_i = 4'b0000;
        #1;
        total++; if (req_o !== 4'b0000) begin bad++; $display("FAIL basic_req_drained got=%b exp=0000", req_o); end
        total++; if (idle_o !== 1'b0) begin bad++; $display("FAIL basic_idle_cnt1 got=%b exp=0", idle_o); end
        rsp_done_i = 1'b1;
        tick();
        rsp_done_i = 1'b0;
        #1;
        total++; if (idle_o !== 1'b1) begin bad++; $display("FAIL basic_idle_after_rsp got=%b exp=1", idle_o); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        gnt_i = 4'b0010; req_i = 1'b1; sel_i = 2'd1;
        for (int k = 0; k < 5; k++) begin
            data_i = 8'h10 + 8'(k);
            #1;
            total++; if (gnt_o !== 1'b1) begin bad++; $display("FAIL b2b_gnt beat=%0d got=%b exp=1", k, gnt_o); end
            tick();
            total++; if (req_o !== 4'b0010) begin bad++; $display("FAIL b2b_req_o beat=%0d got=%b exp=0010", k, req_o); end
            total++; if (data_o !== 8'h10 + 8'(k)) begin bad++; $display("FAIL b2b_data_o beat=%0d got=%h exp=%h", k, data_o, 8'h10 + 8'(k)); end
        end
        req_i = 1'b0;
        tick();
        gnt_i = 4'b0000;
        total++; if (req_o !== 4'b0000) begin bad++; $display("FAIL b2b_req_end got=%b exp=0000", req_o); end
        for (int k = 0; k < 5; k++) begin
            total++; if (idle_o !== 1'b0) begin bad++; $display("FAIL b2b_idle_pending left=%0d got=%b exp=0", 5 - k, idle_o); end
            rsp_done_i = 1'b1;
            tick();
            rsp_done_i = 1'b0;
        end
        total++; if (idle_o !== 1'b1) begin bad++; $display("FAIL b2b_idle_final got=%b exp=1", idle_o); end
    endtask

    task automatic test_lock();
        do_reset();
        gnt_i = 4'b0001; req_i = 1'b1; sel_i = 2'd0; data_i = 8'h01;
        tick();
        tick();
        req_i = 1'b0;
        tick();
        gnt_i = 4'b0000;
        sel_i = 2'd0;
        #1;
        total++; if (gnt_o !== 1'b1) begin bad++; $display("FAIL lock_same_dest got=%b exp=1", gnt_o); end
        sel_i = 2'd3;
        #1;
        total++; if (gnt_o !== 1'b0) begin bad++; $display("FAIL lock_other_noreq got=%b exp=0", gnt_o); end
        req_i = 1'b1; data_i = 8'h33;
        #1;
        total++; if (gnt_o !== 1'b0) begin bad++; $display("FAIL lock_other_req got=%b exp=0", gnt_o); end
        rsp_done_i = 1'b1;
        tick();
        total++; if (gnt_o !== 1'b0) begin bad++; $display("FAIL lock_cnt1 got=%b exp=0", gnt_o); end
        tick();
        rsp_done_i = 1'b0;
        #1;
        total++; if (gnt_o !== 1'b1) begin bad++; $display("FAIL lock_released got=%b exp=1", gnt_o); end
        tick();
        req_i = 1'b0;
        total++; if (req_o !== 4'b1000) begin bad++; $display("FAIL lock_new_req_o got=%b exp=1000", req_o); end
        total++; if (data_o !== 8'h33) begin bad++; $display("FAIL lock_new_data got=%h exp=33", data_o); end
    endtask

    task automatic test_saturation();
        do_reset();
        gnt_i = 4'b0100; req_i = 1'b1; sel_i = 2'd2; data_i = 8'h5A;
        for (int k = 0; k < MaxTrans; k++) begin
            #1;
            total++; if (gnt_o !== 1'b1) begin bad++; $display("FAIL sat_gnt accept=%0d got=%b exp=1", k, gnt_o); end
            tick();
        end
        total++; if (gnt_o !== 1'b0) begin bad++; $display("FAIL sat_ninth_gnt got=%b exp=0", gnt_o); end
        rsp_done_i = 1'b1;
        tick();
        rsp_done_i = 1'b0;
        #1;
        total++; if (gnt_o !== 1'b1) begin bad++; $display("FAIL sat_after_rsp got=%b exp=1", gnt_o); end
        total++; if (req_o !== 4'b0000) begin bad++; $display("FAIL sat_stage_empty got=%b exp=0000", req_o); end
        tick();
        req_i = 1'b0;
        #1;
        total++; if (req_o !== 4'b0100) begin bad++; $display("FAIL sat_ninth_req_o got=%b exp=0100", req_o); end
        total++; if (gnt_o !== 1'b0) begin bad++; $display("FAIL sat_full_again got=%b exp=0", gnt_o); end
        tick();
        gnt_i = 4'b0000;
        for (int k = 0; k < MaxTrans; k++) begin
            total++; if (idle_o !== 1'b0) begin bad++; $display("FAIL sat_idle_pending left=%0d got=%b exp=0", MaxTrans - k, idle_o); end
            rsp_done_i = 1'b1;
            tick();
            rsp_done_i = 1'b0;
        end
        total++; if (idle_o !== 1'b1) begin bad++; $display("FAIL sat_idle_final got=%b exp=1", idle_o); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        gnt_i = 4'b0010; req_i = 1'b1; sel_i = 2'd1; data_i = 8'h77;
        tick();
        tick();
        tick();
        rsp_done_i = 1'b1;
        #1;
        total++; if (gnt_o !== 1'b1) begin bad++; $display("FAIL simul_gnt got=%b exp=1", gnt_o); end
        tick();
        rsp_done_i = 1'b0;
        req_i = 1'b0;
        tick();
        gnt_i = 4'b0000;
        for (int k = 0; k < 3; k++) begin
            total++; if (idle_o !== 1'b0) begin bad++; $display("FAIL simul_idle_pending left=%0d got=%b exp=0", 3 - k, idle_o); end
            rsp_done_i = 1'b1;
            tick();
            rsp_done_i = 1'b0;
        end
        total++; if (idle_o !== 1'b1) begin bad++; $display("FAIL simul_idle_cnt0 got=%b exp=1", idle_o); end
`ifdef STREAM_DEMUX_ROUTER_ERR_EN
        total++; if (err_o !== 1'b0) begin bad++; $display("FAIL simul_err_before got=%b exp=0", err_o); end
`endif
        rsp_done_i = 1'b1;
        tick();
        rsp_done_i = 1'b0;
        sel_i = 2'd3;
        #1;
        total++; if (idle_o !== 1'b1) begin bad++; $display("FAIL spurious_rsp_idle got=%b exp=1", idle_o); end
        total++; if (gnt_o !== 1'b1) begin bad++; $display("FAIL spurious_rsp_no_wrap got=%b exp=1", gnt_o); end
`ifdef STREAM_DEMUX_ROUTER_ERR_EN
        total++; if (err_o !== 1'b1) begin bad++; $display("FAIL spurious_err_set got=%b exp=1", err_o); end
        tick();
        tick();
        total++; if (err_o !== 1'b1) begin bad++; $display("FAIL spurious_err_sticky got=%b exp=1", err_o); end
`endif
    endtask

    task automatic test_reset_mid();
        do_reset();
        gnt_i = 4'b0001; req_i = 1'b1; sel_i = 2'd0; data_i = 8'hC3;
        for (int k = 0; k < 4; k++) tick();
        req_i = 1'b0; gnt_i = 4'b0000;
        tick();
        total++; if (req_o !== 4'b0001) begin bad++; $display("FAIL rstmid_before got=%b exp=0001", req_o); end
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        #1;
        total++; if (req_o !== 4'b0000) begin bad++; $display("FAIL rstmid_req_o got=%b exp=0000", req_o); end
        total++; if (data_o !== 8'h00) begin bad++; $display("FAIL rstmid_data_o got=%h exp=00", data_o); end
        total++; if (idle_o !== 1'b1) begin bad++; $display("FAIL rstmid_idle got=%b exp=1", idle_o); end
        for (int s = 0; s < NumOut; s++) begin
            sel_i = 2'(s);
            #1;
            total++; if (gnt_o !== 1'b1) begin bad++; $display("FAIL rstmid_gnt sel=%0d got=%b exp=1", s, gnt_o); end
        end
        tick();
        total++; if (req_o !== 4'b0000) begin bad++; $display("FAIL rstmid_no_persist got=%b exp=0000", req_o); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_lock();
        test_saturation();
        test_simultaneous();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
